// File: rtl/fifo_read_packer.sv
// fifo_read_packer: read-side consumer for the async FIFO. Pops DSIZE-bit
// entries and packs PACK of them into one wide word, first-popped entry in
// lane 0, presented on a valid/ready stream. A flush emits a partial word.
//
// Ports:
//   rclk, rrst        read-domain clock, synchronous active-high reset
//   rdata, rempty     FIFO head entry and empty flag
//   rinc              pop strobe (combinational)
//   flush             request to emit the current partial word
//   out_data/keep/last/valid, out_ready   packed output stream
//   busy              partial data, a held word or a pending flush exists
module fifo_read_packer #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned PACK  = 4
) (
   input  logic                   rclk,
   input  logic                   rrst,
   input  logic [DSIZE-1:0]       rdata,
   input  logic                   rempty,
   output logic                   rinc,
   input  logic                   flush,
   output logic [DSIZE*PACK-1:0]  out_data,
   output logic [PACK-1:0]        out_keep,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   localparam int unsigned CW = $clog2(PACK);
   localparam int unsigned AW = (PACK - 1 > 1) ? $clog2(PACK - 1) : 1;
   localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);

   logic [PACK-2:0][DSIZE-1:0] acc;
   logic [CW-1:0]              cnt;
   logic                       flush_pend;

   logic                       slot_free;
   logic                       flush_act;
   logic [PACK-1:0][DSIZE-1:0] part_data;
   logic [PACK-1:0]            part_keep;

   // Handshake/flush qualifiers and the pop strobe
   always_comb begin
      slot_free = !out_valid || out_ready;
      flush_act = flush || flush_pend;
      rinc      = !rrst && !rempty && !flush_act && ((cnt < LAST_LANE) || slot_free);
      busy      = (cnt != '0) || out_valid || flush_pend;
   end

   // Partial word: lanes below cnt from acc, the rest forced to zero
   always_comb begin
      part_data = '0;
      part_keep = '0;
      for (int unsigned i = 0; i < PACK - 1; i++) begin
         if (CW'(i) < cnt) begin
            part_data[CW'(i)] = acc[AW'(i)];
            part_keep[CW'(i)] = 1'b1;
         end
      end
   end

   // Accumulator, lane counter, output register and flush tracking
   always_ff @(posedge rclk) begin
      if (rrst) begin
         acc        <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         out_data   <= '0;
         out_keep   <= '0;
         out_last   <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         // Accepted word retires unless a new one loads below at this edge
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (rinc) begin
            if (cnt < LAST_LANE) begin
               acc[AW'(cnt)] <= rdata;
               cnt           <= cnt + CW'(1);
            end else begin
               // Final lane goes straight from rdata into the output word
               out_data  <= {rdata, acc};
               out_keep  <= '1;
               out_last  <= 1'b0;
               out_valid <= 1'b1;
               cnt       <= '0;
            end
         end else if (flush_act) begin
            if (slot_free) begin
               if (cnt != '0) begin
                  out_data  <= part_data;
                  out_keep  <= part_keep;
                  out_last  <= 1'b1;
                  out_valid <= 1'b1;
                  cnt       <= '0;
               end
               flush_pend <= 1'b0;
            end else begin
               // Remember the request until the held word drains
               flush_pend <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: a queue models the FIFO, and a
// scoreboard of expected words is compared against every presented word.
module tb_fifo_read_packer;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        rclk;
   logic        rrst;
   logic [7:0]  rdata;
   logic        rempty;
   logic        rinc;
   logic        flush;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] fq[$];
   word_t      exp_q[$];

   fifo_read_packer #(.DSIZE(8), .PACK(4)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rdata     (rdata),
      .rempty    (rempty),
      .rinc      (rinc),
      .flush     (flush),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv_edge;
      @(posedge rclk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
      word_t w;
      w.data = d;
      w.keep = k;
      w.last = l;
      exp_q.push_back(w);
   endtask

   // FIFO model: pop on rinc sampled at the edge, then present the new head
   initial begin
      logic pop_now;
      rempty = 1'b1;
      rdata  = '0;
      #2;
      rempty = (fq.size() == 0);
      rdata  = rempty ? 8'h00 : fq[0];
      forever begin
         @(posedge rclk);
         pop_now = rinc;
         #2;
         if (pop_now && fq.size() > 0) void'(fq.pop_front());
         rempty = (fq.size() == 0);
         rdata  = rempty ? 8'h00 : fq[0];
      end
   end

   // Output scoreboard and rinc/rempty legality, sampled mid-cycle
   always @(negedge rclk) begin
      chk("rinc_while_empty", 64'(rinc & rempty), 64'd0);
      if (!rrst && out_valid) begin
         chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            chk("sb_data", 64'(out_data), 64'(exp_q[0].data));
            chk("sb_keep", 64'(out_keep), 64'(exp_q[0].keep));
            chk("sb_last", 64'(out_last), 64'(exp_q[0].last));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rrst      = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      fq.push_back(8'h55);

      // Reset: nothing pops, everything cleared after the first edge
      @(negedge rclk);
      chk("rst_rinc", 64'(rinc), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_keep", 64'(out_keep), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cnt", 64'(dut.cnt), 64'd0);
      chk("rst_pend", 64'(dut.flush_pend), 64'd0);
      @(negedge rclk);
      chk("rst_rinc2", 64'(rinc), 64'd0);
      drv_edge();
      fq.delete();
      rrst = 1'b0;
      @(negedge rclk);
      chk("idle_busy", 64'(busy), 64'd0);

      // Streaming: 8 back-to-back pops, two full words
      drv_edge();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
      push_exp(32'h04030201, 4'hF, 1'b0);
      push_exp(32'h08070605, 4'hF, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge rclk);
         chk("stream_rinc", 64'(rinc), 64'd1);
         chk("stream_valid", 64'(out_valid), 64'(i == 4));
      end
      @(negedge rclk);
      chk("stream_valid2", 64'(out_valid), 64'd1);
      chk("stream_rinc_end", 64'(rinc), 64'd0);
      drv_edge();
      @(negedge rclk);
      chk("stream_drain", 64'(out_valid), 64'd0);
      chk("stream_busy", 64'(busy), 64'd0);

      // Backpressure: word held, three lanes accumulate, final lane waits
      drv_edge();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
      push_exp(32'h04030201, 4'hF, 1'b0);
      push_exp(32'h08070605, 4'hF, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge rclk);
         chk("bp_rinc", 64'(rinc), 64'(i < 7));
      end
      chk("bp_cnt", 64'(dut.cnt), 64'd3);
      drv_edge();
      @(negedge rclk);
      chk("bp_stall", 64'(rinc), 64'd0);
      chk("bp_hold", 64'(out_valid), 64'd1);
      drv_edge();
      out_ready = 1'b1;
      @(negedge rclk);
      chk("bp_release", 64'(rinc), 64'd1);
      drv_edge();
      @(negedge rclk);
      chk("bp_word2", 64'(out_valid), 64'd1);
      chk("bp_keep2", 64'(out_keep), 64'hF);
      drv_edge();
      @(negedge rclk);
      chk("bp_drain", 64'(out_valid), 64'd0);

      // Flush partial: two lanes, then a one-cycle flush pulse
      drv_edge();
      fq.push_back(8'hAA);
      fq.push_back(8'hBB);
      push_exp(32'h0000BBAA, 4'h3, 1'b1);
      drv_edge();
      drv_edge();
      flush = 1'b1;
      @(negedge rclk);
      chk("fp_rinc", 64'(rinc), 64'd0);
      chk("fp_cnt", 64'(dut.cnt), 64'd2);
      chk("fp_novalid", 64'(out_valid), 64'd0);
      drv_edge();
      flush = 1'b0;
      @(negedge rclk);
      chk("fp_valid", 64'(out_valid), 64'd1);
      chk("fp_data", 64'(out_data), 64'h0000BBAA);
      chk("fp_keep", 64'(out_keep), 64'h3);
      chk("fp_last", 64'(out_last), 64'd1);
      drv_edge();
      @(negedge rclk);
      chk("fp_drain", 64'(out_valid), 64'd0);
      chk("fp_busy", 64'(busy), 64'd0);

      // Flush while the output slot is blocked
      drv_edge();
      out_ready = 1'b0;
      fq.push_back(8'h11);
      fq.push_back(8'h22);
      fq.push_back(8'h33);
      fq.push_back(8'h44);
      fq.push_back(8'hCC);
      push_exp(32'h44332211, 4'hF, 1'b0);
      push_exp(32'h000000CC, 4'h1, 1'b1);
      repeat (5) drv_edge();
      flush = 1'b1;
      fq.push_back(8'hDD);
      @(negedge rclk);
      chk("fb_rinc", 64'(rinc), 64'd0);
      chk("fb_cnt", 64'(dut.cnt), 64'd1);
      chk("fb_held", 64'(out_valid), 64'd1);
      drv_edge();
      flush = 1'b0;
      @(negedge rclk);
      chk("fb_pend", 64'(dut.flush_pend), 64'd1);
      chk("fb_rinc_pend", 64'(rinc), 64'd0);
      chk("fb_busy", 64'(busy), 64'd1);
      drv_edge();
      out_ready = 1'b1;
      @(negedge rclk);
      chk("fb_rinc_hs", 64'(rinc), 64'd0);
      drv_edge();
      @(negedge rclk);
      chk("fb_pend_clr", 64'(dut.flush_pend), 64'd0);
      chk("fb_valid", 64'(out_valid), 64'd1);
      chk("fb_data", 64'(out_data), 64'h000000CC);
      chk("fb_keep", 64'(out_keep), 64'h1);
      chk("fb_last", 64'(out_last), 64'd1);
      chk("fb_resume", 64'(rinc), 64'd1);
      drv_edge();
      fq.push_back(8'hEE);
      fq.push_back(8'hFF);
      fq.push_back(8'h77);
      push_exp(32'h77FFEEDD, 4'hF, 1'b0);
      repeat (3) drv_edge();
      @(negedge rclk);
      chk("fb_full", 64'(out_valid), 64'd1);
      chk("fb_full_keep", 64'(out_keep), 64'hF);
      drv_edge();
      flush = 1'b1;
      @(negedge rclk);
      chk("f0_cnt", 64'(dut.cnt), 64'd0);
      chk("f0_novalid", 64'(out_valid), 64'd0);
      drv_edge();
      flush = 1'b0;
      @(negedge rclk);
      chk("f0_noword", 64'(out_valid), 64'd0);
      chk("f0_pend", 64'(dut.flush_pend), 64'd0);
      chk("f0_busy", 64'(busy), 64'd0);

      // Reset mid-word: held word and partial lanes are discarded
      drv_edge();
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) fq.push_back(8'(i));
      push_exp(32'h04030201, 4'hF, 1'b0);
      repeat (6) drv_edge();
      rrst = 1'b1;
      exp_q.delete();
      fq.push_back(8'hA1);
      fq.push_back(8'hA2);
      fq.push_back(8'hA3);
      fq.push_back(8'hA4);
      push_exp(32'hA4A3A2A1, 4'hF, 1'b0);
      @(negedge rclk);
      chk("rm_valid_pre", 64'(out_valid), 64'd1);
      chk("rm_cnt_pre", 64'(dut.cnt), 64'd2);
      chk("rm_rinc", 64'(rinc), 64'd0);
      drv_edge();
      rrst = 1'b0;
      out_ready = 1'b1;
      @(negedge rclk);
      chk("rm_valid", 64'(out_valid), 64'd0);
      chk("rm_cnt", 64'(dut.cnt), 64'd0);
      repeat (4) drv_edge();
      @(negedge rclk);
      chk("rm_word", 64'(out_valid), 64'd1);
      chk("rm_keep", 64'(out_keep), 64'hF);
      drv_edge();
      @(negedge rclk);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      chk("end_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_read_packer.md
# fifo_read_packer

Read-side consumer for the async FIFO, clocked entirely in the read domain. It pops DSIZE-bit entries from the FIFO read port (rdata/rempty/rinc) and packs PACK consecutive entries into one wide word. It presents each word on a valid/ready output stream, and a flush request emits a partially filled word early. It sits directly downstream of the FIFO, between the FIFO and any wide-bus consumer.

## Interface
- DSIZE, 8, width of one FIFO entry; must match the FIFO's DSIZE.
- PACK, 4, entries per output word, PACK >= 2.
- rclk  input  1  read-domain clock; all logic is on its rising edge.
- rrst  input  1  reset; synchronous, active-high, in the rclk domain.
- rdata  input  DSIZE  FIFO head entry; valid whenever rempty=0.
- rempty  input  1  FIFO empty flag.
- rinc  output  1  pop strobe; consumes the head entry at the rclk edge.
- flush  input  1  request to emit the current partial word.
- out_data  output  DSIZE*PACK  packed word; the first-popped entry is in bits [DSIZE-1:0].
- out_keep  output  PACK  lane-valid mask; bit i covers lane i.
- out_last  output  1  marks a word that was terminated by flush.
- out_valid  output  1  out_data, out_keep and out_last are valid.
- out_ready  input  1  the consumer accepts the word when out_valid=1 and out_ready=1.
- busy  output  1  high when cnt!=0, out_valid=1 or flush_pend=1.

## Operation
- State:
  - accumulator acc, holding PACK-1 lanes;
  - lane counter cnt, range 0..PACK-1;
  - output register (out_data, out_keep, out_last, out_valid);
  - flush_pend flag.
- Signal definitions:
  - slot_free = !out_valid | out_ready
  - flush_act = flush | flush_pend
- Pop rule: rinc = !rrst & !rempty & !flush_act & (cnt < PACK-1 | slot_free). rinc is never asserted while rempty=1.
- Pop with cnt < PACK-1: rdata is written into acc lane cnt, and cnt increments.
- Pop with cnt = PACK-1 (slot_free is guaranteed by the pop rule):
  - out_data <= {rdata, acc lanes PACK-2..0};
  - out_keep <= all ones;
  - out_last <= 0;
  - out_valid <= 1;
  - cnt <= 0.
- Output handshake:
  - out_valid & out_ready with no new word loading: out_valid <= 0 at the edge.
  - A new word and a handshake at the same edge: the new word loads and out_valid stays 1.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_keep and out_last hold stable.
- Flush, evaluated each cycle with flush_act=1:
  - slot_free=1 and cnt>0:
    - out_data <= acc, with unused lanes forced to zero;
    - out_keep <= (1<<cnt)-1;
    - out_last <= 1;
    - out_valid <= 1;
    - cnt <= 0;
    - flush_pend <= 0.
  - slot_free=1 and cnt=0: flush_pend <= 0 and no word is emitted.
  - slot_free=0: flush_pend <= 1. Popping stays stalled until the flush resolves.
- Flush and pop in the same cycle: cannot occur, because flush gates rinc combinationally.
- Width rules:
  - cnt is $clog2(PACK) bits wide.
  - out_keep is contiguous from lane 0.
  - Full words have out_keep all ones and out_last=0.
  - Zero-lane words are never emitted.

## Timing
- Reset: at the first rclk edge with rrst=1, the following are cleared to 0:
  - out_data, out_keep, out_last, out_valid;
  - cnt, acc, flush_pend;
  - busy (the signals it derives from are all cleared).
- rinc is combinationally 0 while rrst=1.
- Reset mid-operation discards any partial acc contents and any held word. No entries are popped during reset.
- Latency: the final-lane pop in cycle T gives out_valid=1 in cycle T+1. A flush in cycle T with slot_free=1 gives the partial word valid in T+1.
- Throughput: with rempty=0 and out_ready=1 continuously, rinc stays high every cycle and one word is emitted every PACK cycles with no bubbles.
- Backpressure: with out_valid=1 and out_ready=0, popping continues until cnt=PACK-1, then rinc=0. The cycle out_ready rises, the final lane pops and the next word loads at that edge.

## Test plan
- **Reset:** rrst=1 for 2 cycles with rempty=0 and flush=0 -> rinc=0 throughout, and all outputs are 0 after the first edge.
- **Streaming:** PACK=4, entries 0x01..0x08, out_ready=1 -> rinc high for 8 consecutive cycles. Words are 0x04030201 then 0x08070605, both with out_keep=0xF and out_last=0, one cycle after the 4th and 8th pops.
- **Backpressure:**
  - Stimulus: 8 entries 0x01..0x08 with out_ready=0.
  - Required: word 0x04030201 holds stable; 0x05..0x07 accumulate; rinc=0 while 0x08 sits at the head.
  - Raise out_ready: 0x08 pops that cycle and 0x08070605 is valid next cycle.
- **Flush partial:** entries 0xAA then 0xBB, then rempty=1 and a 1-cycle flush pulse -> next cycle out_data=0x0000BBAA, out_keep=0x3, out_last=1.
- **Flush while blocked:**
  - Stimulus: out_valid=1, out_ready=0, cnt=1 holding 0xCC, then a 1-cycle flush pulse.
  - Required: flush_pend=1 and rinc=0. After the handshake, out_data=0x000000CC, out_keep=0x1, out_last=1.
  - A later flush with cnt=0 emits no word, and busy drops to 0.
- **Reset mid-word:** rrst pulse while out_valid=1 and cnt=2 -> next cycle out_valid=0 and cnt=0. The next 4 entries form one clean word with out_keep=0xF.
